char_to_int: RTL and testbench
==============================

// Module: char_to_int
// PURPOSE
// - ASCII character decoder for the UART/keypad number-entry path: maps one 8-bit ASCII char to a 4-bit digit value plus a character class.
// - Combinational outputs serve the 4-digit string-to-integer assembler (num3..num0 taps, sign char 8'h2D).
// - Registered outputs, with valid and sticky-error, serve the streaming char path.
// PARAMETERS
// - HEX_EN   0  1: also decode '0'-'9','A'-'F','a'-'f' to 0..15; 0: decimal digits only
// PORTS
// - clk        in   1  system clock, rising edge
// - rst_n      in   1  asynchronous active-low reset
// - c          in   8  ASCII character (combinational decode input)
// - num        out  4  combinational digit value of c; 4'd0 when c is not a digit
// - in_valid   in   1  c is a valid stream character this cycle
// - err_clr    in   1  synchronous clear of err_sticky
// - out_valid  out  1  registered: registered outputs hold a new char
// - num_q      out  4  registered num
// - is_digit_q out  1  char was a (hex-)digit per HEX_EN
// - is_minus_q out  1  char == 8'h2D '-'
// - is_plus_q  out  1  char == 8'h2B '+'
// - is_ws_q    out  1  char is 8'h20, 8'h0D or 8'h0A
// - is_other_q out  1  char matched none of the above classes
// - err_sticky out  1  set when a valid char was classed "other"
// BEHAVIOUR
// - Decimal decode: 8'h30..8'h39 -> c-8'h30 (0..9).
// - Hex decode (HEX_EN=1 only): 8'h41..8'h46 and 8'h61..8'h66 -> 10..15.
// - Non-digit chars -> num 4'd0. num never produces X for any of the 256 inputs.
// - HEX_EN=0: 'A'-'F' / 'a'-'f' are class "other".
// - num is purely combinational, zero latency, independent of clk/rst_n and in_valid.
// - Classes are one-hot: exactly one of is_digit/is_minus/is_plus/is_ws/is_other is 1 for any char.
// - Latency is 1 cycle. On each clk edge with in_valid=1:
//   - num_q and the class flags load the decode of c;
//   - out_valid <= in_valid.
// - in_valid=0: out_valid <= 0. num_q and the class flags hold their last value.
// - err_sticky update each edge:
//   - set when in_valid=1 and the char is class "other";
//   - cleared on err_clr=1;
//   - err_clr and a set in the same cycle: set wins, err_sticky=1.
// - Reset (rst_n=0), asynchronous, any time including mid-stream:
//   - out_valid, num_q, err_sticky, all class flags -> 0;
//   - outputs stay 0 until the first valid char after rst_n deasserts.
// - No backpressure. Back-to-back valid chars are accepted every cycle.
// STRUCTURE
// - Shared package: ASCII constants (CH_0=8'h30, CH_9=8'h39, CH_MINUS=8'h2D, CH_PLUS=8'h2B, CH_SP=8'h20, CH_CR=8'h0D, CH_LF=8'h0A, CH_A/CH_a) and the class enum.
// - Sub-module char_decode_comb: pure combinational decode (num plus class vector), instanced once.
// - Top level holds only the output register stage and err_sticky.
// TESTING
// - Sweep c over 8'h00..8'hFF with HEX_EN=0:
//   - num = c-8'h30 for '0'..'9', else 0;
//   - class flags are one-hot for every value.
// - HEX_EN=1:
//   - 'A'(8'h41) -> 10, 'f'(8'h66) -> 15;
//   - 'G'(8'h47) -> 0, is_other_q=1.
// - Stream "-","1","2","3","4" on consecutive cycles:
//   - out_valid high cycles 1..5;
//   - first is_minus_q=1, then num_q = 1,2,3,4.
// - Valid 'x', then 2 idle cycles, then err_clr: err_sticky stays 1 until the cycle after err_clr.
// - Valid 'x' with err_clr=1 in the same cycle: err_sticky=1.
// - Reset mid-stream after '7': all registered outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/char_to_int_pkg.sv
// ---------------------------------------------------------------------------
// char_to_int_pkg
// Shared ASCII constants and character-class definitions for the
// number-entry character path (char_decode_comb, char_to_int).
//
// Contents:
//   CH_*            ASCII code points recognised by the decoder
//   char_class_e    enumeration of the five character classes
//   CLS_*_BIT       bit positions of each class in the one-hot class vector
//   class_onehot()  converts a class enum into the one-hot class vector
// ---------------------------------------------------------------------------
package char_to_int_pkg;

    // ASCII code points
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_F     = 8'h46;
    localparam logic [7:0] CH_a     = 8'h61;
    localparam logic [7:0] CH_f     = 8'h66;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    // Character classes; exactly one applies to any 8-bit code
    typedef enum logic [2:0] {
        CLS_OTHER = 3'd0,
        CLS_DIGIT = 3'd1,
        CLS_MINUS = 3'd2,
        CLS_PLUS  = 3'd3,
        CLS_WS    = 3'd4
    } char_class_e;

    // One-hot class vector layout: {digit, minus, plus, ws, other}
    localparam int CLS_W         = 5;
    localparam int CLS_DIGIT_BIT = 4;
    localparam int CLS_MINUS_BIT = 3;
    localparam int CLS_PLUS_BIT  = 2;
    localparam int CLS_WS_BIT    = 1;
    localparam int CLS_OTHER_BIT = 0;

    // Deriving the flags from a single enum value keeps them one-hot by
    // construction; anything unexpected falls back to "other".
    function automatic logic [CLS_W-1:0] class_onehot(input char_class_e k);
        logic [CLS_W-1:0] v;
        v = '0;
        case (k)
            CLS_DIGIT: v[CLS_DIGIT_BIT] = 1'b1;
            CLS_MINUS: v[CLS_MINUS_BIT] = 1'b1;
            CLS_PLUS:  v[CLS_PLUS_BIT]  = 1'b1;
            CLS_WS:    v[CLS_WS_BIT]    = 1'b1;
            default:   v[CLS_OTHER_BIT] = 1'b1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/char_to_int_decode_comb.sv
// ---------------------------------------------------------------------------
// char_decode_comb
// Purely combinational ASCII character decoder: maps one character to a
// 4-bit digit value and a one-hot class vector.
//
// Parameters:
//   HEX_EN  0: decimal digits only; 1: also 'A'-'F' / 'a'-'f' -> 10..15
// Ports:
//   c    in   8  ASCII character
//   num  out  4  digit value of c, 4'd0 when c is not a digit
//   cls  out  5  one-hot class vector {digit, minus, plus, ws, other}
// ---------------------------------------------------------------------------
module char_decode_comb
    import char_to_int_pkg::*;
#(
    parameter bit HEX_EN = 1'b0
) (
    input  logic [7:0]       c,
    output logic [3:0]       num,
    output logic [CLS_W-1:0] cls
);

    char_class_e kind;

    always_comb begin
        num  = 4'd0;
        kind = CLS_OTHER;
        if (c >= CH_0 && c <= CH_9) begin
            // '0'..'9' sit at 8'h30..8'h39, so the low nibble is the value
            num  = c[3:0];
            kind = CLS_DIGIT;
        end else if (HEX_EN && ((c >= CH_A && c <= CH_F) || (c >= CH_a && c <= CH_f))) begin
            // 'A'/'a' have low nibble 1, so value = low nibble + 9
            num  = c[3:0] + 4'd9;
            kind = CLS_DIGIT;
        end else if (c == CH_MINUS) begin
            kind = CLS_MINUS;
        end else if (c == CH_PLUS) begin
            kind = CLS_PLUS;
        end else if (c == CH_SP || c == CH_CR || c == CH_LF) begin
            kind = CLS_WS;
        end
    end

    assign cls = class_onehot(kind);

endmodule

// File: rtl/char_to_int.sv
// ---------------------------------------------------------------------------
// char_to_int
// ASCII character decoder for the UART/keypad number-entry path.
// The combinational num output feeds the string-to-integer assembler; the
// registered outputs (1-cycle latency) feed the streaming character path,
// together with a sticky error flag for unexpected characters.
//
// Parameters:
//   HEX_EN      0: decimal digits only; 1: also hex digits A-F / a-f
// Ports:
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   c           in   8  ASCII character
//   num         out  4  combinational digit value of c (0 if not a digit)
//   in_valid    in   1  c is a valid stream character this cycle
//   err_clr     in   1  synchronous clear of err_sticky
//   out_valid   out  1  registered outputs hold a new character
//   num_q       out  4  registered digit value
//   is_digit_q  out  1  registered class: (hex-)digit
//   is_minus_q  out  1  registered class: '-'
//   is_plus_q   out  1  registered class: '+'
//   is_ws_q     out  1  registered class: space, CR or LF
//   is_other_q  out  1  registered class: none of the above
//   err_sticky  out  1  set by a valid "other" char, cleared by err_clr
// ---------------------------------------------------------------------------
module char_to_int
    import char_to_int_pkg::*;
#(
    parameter bit HEX_EN = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] c,
    output logic [3:0] num,
    input  logic       in_valid,
    input  logic       err_clr,
    output logic       out_valid,
    output logic [3:0] num_q,
    output logic       is_digit_q,
    output logic       is_minus_q,
    output logic       is_plus_q,
    output logic       is_ws_q,
    output logic       is_other_q,
    output logic       err_sticky
);

    logic [CLS_W-1:0] cls_d;
    logic [CLS_W-1:0] cls_q;

    char_decode_comb #(
        .HEX_EN (HEX_EN)
    ) u_decode (
        .c   (c),
        .num (num),
        .cls (cls_d)
    );

    // Output register stage: data holds while no valid char arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            num_q     <= 4'd0;
            cls_q     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                num_q <= num;
                cls_q <= cls_d;
            end
        end
    end

    // A new error takes priority over a simultaneous clear so it is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (in_valid && cls_d[CLS_OTHER_BIT]) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

    assign is_digit_q = cls_q[CLS_DIGIT_BIT];
    assign is_minus_q = cls_q[CLS_MINUS_BIT];
    assign is_plus_q  = cls_q[CLS_PLUS_BIT];
    assign is_ws_q    = cls_q[CLS_WS_BIT];
    assign is_other_q = cls_q[CLS_OTHER_BIT];

endmodule

// File: tb/tb_char_to_int.sv
// ---------------------------------------------------------------------------
// tb_char_to_int
// Scoreboard bench for char_to_int. Two instances share the stimulus:
// dut0 with HEX_EN=0 and dut1 with HEX_EN=1. Each issued character pushes
// the expected registered result per instance; monitors pop on out_valid.
// ---------------------------------------------------------------------------
module tb_char_to_int;

    typedef struct packed {
        logic [3:0] n;
        logic [4:0] k;   // {digit, minus, plus, ws, other}
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] c;
    logic       in_valid;
    logic       err_clr;

    logic [3:0] num0, num_q0, num1, num_q1;
    logic       ov0, dig0, min0, pls0, ws0, oth0, err0;
    logic       ov1, dig1, min1, pls1, ws1, oth1, err1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    char_to_int #(.HEX_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .c(c), .num(num0), .in_valid(in_valid),
        .err_clr(err_clr), .out_valid(ov0), .num_q(num_q0),
        .is_digit_q(dig0), .is_minus_q(min0), .is_plus_q(pls0),
        .is_ws_q(ws0), .is_other_q(oth0), .err_sticky(err0)
    );

    char_to_int #(.HEX_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .c(c), .num(num1), .in_valid(in_valid),
        .err_clr(err_clr), .out_valid(ov1), .num_q(num_q1),
        .is_digit_q(dig1), .is_minus_q(min1), .is_plus_q(pls1),
        .is_ws_q(ws1), .is_other_q(oth1), .err_sticky(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference classification written from the character table directly
    function automatic exp_t exp_dec(input logic [7:0] ch, input bit hex);
        exp_t e;
        logic [7:0] t;
        e.n = 4'd0;
        e.k = 5'b00001;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            t = ch - 8'h30;
            e.n = t[3:0];
            e.k = 5'b10000;
        end else if (hex && ch >= 8'h41 && ch <= 8'h46) begin
            t = ch - 8'h41 + 8'd10;
            e.n = t[3:0];
            e.k = 5'b10000;
        end else if (hex && ch >= 8'h61 && ch <= 8'h66) begin
            t = ch - 8'h61 + 8'd10;
            e.n = t[3:0];
            e.k = 5'b10000;
        end else if (ch == 8'h2D) begin
            e.k = 5'b01000;
        end else if (ch == 8'h2B) begin
            e.k = 5'b00100;
        end else if (ch == 8'h20 || ch == 8'h0D || ch == 8'h0A) begin
            e.k = 5'b00010;
        end
        return e;
    endfunction

    task automatic send(input logic [7:0] ch, input logic clr);
        @(negedge clk);
        c        = ch;
        in_valid = 1'b1;
        err_clr  = clr;
        q0.push_back(exp_dec(ch, 1'b0));
        q1.push_back(exp_dec(ch, 1'b1));
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = clr;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ov0"},  {7'd0, ov0}, 8'd0);
        chk({tag, "_num0"}, {4'd0, num_q0}, 8'd0);
        chk({tag, "_cls0"}, {3'd0, dig0, min0, pls0, ws0, oth0}, 8'd0);
        chk({tag, "_err0"}, {7'd0, err0}, 8'd0);
        chk({tag, "_ov1"},  {7'd0, ov1}, 8'd0);
        chk({tag, "_num1"}, {4'd0, num_q1}, 8'd0);
        chk({tag, "_cls1"}, {3'd0, dig1, min1, pls1, ws1, oth1}, 8'd0);
        chk({tag, "_err1"}, {7'd0, err1}, 8'd0);
    endtask

    // Monitors: compare registered outputs whenever out_valid is presented
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov0) begin
            if (q0.size() == 0) begin
                chk("sb0_underflow", 8'd1, 8'd0);
            end else begin
                e = q0.pop_front();
                chk("sb0_num_q", {4'd0, num_q0}, {4'd0, e.n});
                chk("sb0_class", {3'd0, dig0, min0, pls0, ws0, oth0}, {3'd0, e.k});
                chk("sb0_onehot", {7'd0, $onehot({dig0, min0, pls0, ws0, oth0})}, 8'd1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov1) begin
            if (q1.size() == 0) begin
                chk("sb1_underflow", 8'd1, 8'd0);
            end else begin
                e = q1.pop_front();
                chk("sb1_num_q", {4'd0, num_q1}, {4'd0, e.n});
                chk("sb1_class", {3'd0, dig1, min1, pls1, ws1, oth1}, {3'd0, e.k});
                chk("sb1_onehot", {7'd0, $onehot({dig1, min1, pls1, ws1, oth1})}, 8'd1);
            end
        end
    end

    initial begin
        exp_t e;
        rst_n    = 1'b0;
        c        = 8'h35;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        #1;
        chk_all_zero("reset");
        // combinational path works while reset is held
        chk("comb_in_reset", {4'd0, num0}, 8'd5);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        chk_all_zero("post_reset");

        // Stream "-1234"
        send(8'h2D, 1'b0);
        send(8'h31, 1'b0);
        chk("stream_ov1", {7'd0, ov0}, 8'd1);
        chk("stream_minus", {7'd0, min0}, 8'd1);
        send(8'h32, 1'b0);
        chk("stream_n1", {4'd0, num_q0}, 8'd1);
        send(8'h33, 1'b0);
        chk("stream_n2", {4'd0, num_q0}, 8'd2);
        send(8'h34, 1'b0);
        chk("stream_n3", {4'd0, num_q0}, 8'd3);
        idle(1'b0);
        chk("stream_n4", {4'd0, num_q0}, 8'd4);
        chk("stream_ov5", {7'd0, ov0}, 8'd1);
        chk("stream_dig", {7'd0, dig0}, 8'd1);
        idle(1'b0);
        chk("stream_ov_off", {7'd0, ov0}, 8'd0);
        chk("stream_hold", {4'd0, num_q0}, 8'd4);
        chk("stream_noerr", {7'd0, err0}, 8'd0);

        // 'x', two idle cycles, then err_clr
        send(8'h78, 1'b0);
        idle(1'b0);
        chk("err_set", {7'd0, err0}, 8'd1);
        chk("err_other_q", {7'd0, oth0}, 8'd1);
        idle(1'b0);
        chk("err_hold1", {7'd0, err0}, 8'd1);
        idle(1'b1);
        chk("err_hold2", {7'd0, err0}, 8'd1);
        idle(1'b0);
        chk("err_cleared", {7'd0, err0}, 8'd0);

        // 'x' together with err_clr: set wins
        send(8'h78, 1'b1);
        idle(1'b0);
        chk("err_set_wins", {7'd0, err0}, 8'd1);
        idle(1'b1);
        idle(1'b0);
        chk("err_clr2", {7'd0, err0}, 8'd0);

        // Hex decode differences between the two instances
        send(8'h41, 1'b0);
        send(8'h66, 1'b0);
        chk("hex_A_num", {4'd0, num_q1}, 8'd10);
        chk("hex_A_dig", {7'd0, dig1}, 8'd1);
        chk("dec_A_oth", {7'd0, oth0}, 8'd1);
        send(8'h47, 1'b0);
        chk("hex_f_num", {4'd0, num_q1}, 8'd15);
        idle(1'b0);
        chk("hex_G_num", {4'd0, num_q1}, 8'd0);
        chk("hex_G_oth", {7'd0, oth1}, 8'd1);
        chk("hex_G_err", {7'd0, err1}, 8'd1);
        idle(1'b1);
        idle(1'b0);

        // Full 256-code sweep, combinational and registered
        for (int i = 0; i < 256; i++) begin
            send(i[7:0], 1'b0);
            #1;
            e = exp_dec(i[7:0], 1'b0);
            chk("sweep_num0", {4'd0, num0}, {4'd0, e.n});
            e = exp_dec(i[7:0], 1'b1);
            chk("sweep_num1", {4'd0, num1}, {4'd0, e.n});
        end
        idle(1'b0);
        idle(1'b0);
        chk("q0_drained", q0.size() == 0 ? 8'd1 : 8'd0, 8'd1);
        chk("q1_drained", q1.size() == 0 ? 8'd1 : 8'd0, 8'd1);

        // Asynchronous reset mid-stream after '7'
        send(8'h37, 1'b0);
        send(8'h38, 1'b0);
        chk("pre_rst_num", {4'd0, num_q0}, 8'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        q0.delete();
        q1.delete();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        chk_all_zero("after_rst");
        idle(1'b0);
        chk("final_q0", q0.size() == 0 ? 8'd1 : 8'd0, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
